// File: rtl/div_iterative.sv
// Multicycle signed restoring divider: one quotient bit per clock, fixed 32-cycle latency,
// single-cycle ready pulse with quotient, remainder and exception flag.

module sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);
    logic [WIDTH:0] full;

    assign full       = {1'b0, minuend} - {1'b0, subtrahend};
    assign difference = full[WIDTH-1:0];
    assign borrow     = full[WIDTH];
endmodule

module div_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] remainder;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic             overflow;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        rem_shift;
    logic [WIDTH-1:0]        trial;
    logic                    trial_borrow;
    logic [WIDTH-1:0]        rem_next;
    logic [WIDTH-1:0]        quo_next;

    // Magnitude of a two's-complement value; -2^(W-1) maps to its unsigned pattern.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign a_s = data_operandA;
    assign b_s = data_operandB;

    // The dividend register doubles as the quotient: quotient bits shift in at the LSB.
    assign rem_shift = {remainder[WIDTH-2:0], dividend[WIDTH-1]};

    sub #(.WIDTH(WIDTH)) u_sub (
        .minuend    (rem_shift),
        .subtrahend (divisor),
        .difference (trial),
        .borrow     (trial_borrow)
    );

    assign rem_next = trial_borrow ? rem_shift : trial;
    assign quo_next = {dividend[WIDTH-2:0], ~trial_borrow};

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                // A start in any state discards whatever was in flight.
                state     <= RUN;
                busy      <= 1'b1;
                count     <= '0;
                remainder <= '0;
                sign_a    <= a_s[WIDTH-1];
                sign_b    <= b_s[WIDTH-1];
                dividend  <= abs_mag(a_s);
                divisor   <= abs_mag(b_s);
                div_zero  <= (data_operandB == '0);
                overflow  <= (data_operandA == MIN_NEG) && (data_operandB == '1);
            end else begin
                case (state)
                    RUN: begin
                        remainder <= rem_next;
                        dividend  <= quo_next;
                        count     <= count + 1'b1;
                        if (count == LAST) begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            if (div_zero) begin
                                data_result    <= '0;
                                data_remainder <= '0;
                                data_exception <= 1'b1;
                            end else if (overflow) begin
                                data_result    <= MIN_NEG;
                                data_remainder <= '0;
                                data_exception <= 1'b1;
                            end else begin
                                data_result    <= cond_neg(quo_next, sign_a ^ sign_b);
                                data_remainder <= cond_neg(rem_next, sign_a);
                                data_exception <= 1'b0;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/div_iterative.md
Name: div_iterative

Overview:
- Multicycle 32-bit signed integer divider in the ALU execute path.
- Directly downstream consumer of the ALU `sub` block: one `sub` instance performs the trial subtraction on every iteration.
- Restoring division, one quotient bit per clock; the result is handed back to the execute stage with a one-cycle ready pulse.
- Used by the processor for `div` instructions; the pipeline stalls while the divider is busy.

Parameters:
- WIDTH, 32, operand/result width; also the iteration count. Only 32 is supported by the bench.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_DIV  input  1  start pulse; operands are sampled on the edge where it is 1.
- data_operandA  input  32  dividend, two's complement.
- data_operandB  input  32  divisor, two's complement.
- data_result  output  32  quotient, truncated toward zero.
- data_remainder  output  32  remainder; sign follows the dividend.
- data_exception  output  1  divide-by-zero or overflow flag, valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle result-valid pulse.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (reset asserted at a rising edge of clock).
- Reset: state IDLE, counter 0, and all outputs 0 (data_result, data_remainder, data_exception, data_resultRDY, busy). Reset mid-operation aborts immediately; no ready pulse follows.
- States: IDLE, RUN, DONE.
- IDLE → RUN on an edge with ctrl_DIV=1. At that edge (call it edge N):
  - latch sign(A) and sign(B);
  - latch |A| into the dividend shift register and |B| into the divisor register;
  - clear the partial remainder and counter; busy=1.
- RUN, each edge:
  - remainder = {remainder[30:0], dividend[31]}; dividend shifts left;
  - trial = remainder − divisor, computed via `sub`;
  - if trial ≥ 0 (unsigned borrow clear), remainder = trial and quotient bit = 1; else remainder is kept and quotient bit = 0;
  - counter increments.
- Abs-value handling: all magnitudes are 32-bit unsigned, so |−2^31| = 0x80000000 is handled correctly.
- After the 32nd iteration edge (N+32), state → DONE and the outputs are registered:
  - quotient is negated if sign(A) ≠ sign(B);
  - remainder is negated if sign(A) = 1;
  - data_resultRDY = 1 for the cycle between edges N+32 and N+33;
  - busy = 0 from edge N+32.
- DONE → IDLE at the next edge; data_resultRDY returns to 0.
- data_result, data_remainder and data_exception hold until the next start.
- Latency: fixed 32 cycles from the start edge to ready, independent of operand values, including exception cases.
- Divide by zero (B = 0), flagged at the start edge and reported at ready: data_exception=1, data_result=0, data_remainder=0.
- Overflow (A = 0x80000000, B = 0xFFFFFFFF), reported at ready: data_exception=1, data_result=0x80000000, data_remainder=0.
- Otherwise data_exception = 0.
- ctrl_DIV=1 while in RUN or DONE: restart. New operands are latched, the counter is cleared, the old operation is discarded with no ready pulse for it, and the new ready arrives at the restart edge + 32.
- ctrl_DIV and reset on the same edge: reset wins.
- Operand inputs are ignored except on start edges; they may change freely mid-operation.

Test Plan:
- A=162346, B=24124, start at edge N → data_resultRDY high exactly in cycle N+32..N+33; result 6; remainder 17602; exception 0; busy low from N+32.
- A=−162346, B=24124 → result −6 (0xFFFFFFFA), remainder −17602, exception 0. A=−7, B=−2 → result 3, remainder −1.
- A=7, B=0 → ready at N+32; exception 1; result 0; remainder 0. A=0x80000000, B=−1 → exception 1, result 0x80000000.
- Start with A=100, B=7; at N+10 pulse ctrl_DIV with A=1000, B=3 → no ready at N+32; ready at N+42 with result 333, remainder 1.
- Start with A=50, B=5; assert reset at N+15 → all outputs 0 next cycle; no ready pulse in the next 40 cycles; a subsequent start of 50/5 gives 10 rem 0.
- Change A/B every 10 ns during RUN, with the pattern applied to A=162346, B=24124 → result unaffected (6 rem 17602).
